// File: rtl/ew_fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO push arbiter and related arbiters.
package ew_fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int BEAT_W = 8;
    localparam int TMO_W  = 16;

    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ew_fifo_push_arb_if.sv
// Requester handshake plus FIFO push-side bus; master = arbiter side, slave = environment side.
interface ew_fifo_push_arb_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          push_req_n;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          push_full;
    logic                          push_af;

    modport master (
        input  req_valid, req_data, req_last, push_full, push_af,
        output req_ready, push_req_n, fifo_data
    );

    modport slave (
        output req_valid, req_data, req_last, push_full, push_af,
        input  req_ready, push_req_n, fifo_data
    );
endinterface

// File: rtl/ew_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module ew_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         any_req
);
    logic [W-1:0] idx;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        winner  = '0;
        any_req = |req;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % N);
            if (req[idx]) winner = idx;
        end
    end
endmodule

// File: rtl/ew_fifo_push_arb.sv
// Round-robin burst arbiter sharing one FIFO push port; states: ST_IDLE arbitrate (bubble) | ST_GRANT owner streams.
// Optional idle-owner timeout release is enabled by defining EW_FIFO_ARB_TIMEOUT_EN.
module ew_fifo_push_arb
    import ew_fifo_arb_pkg::*;
#(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 32,
    parameter int  BURST_MAX  = 4,
    parameter int  TIMEOUT    = 16,
    localparam int GID_W      = gid_width(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    ew_fifo_push_arb_if.master bus,
    output logic [GID_W-1:0]   grant_id,
    output logic               busy,
    output logic               timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_MAX < 1 || BURST_MAX > 255 ||
        TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_cfg
        $error("ew_fifo_push_arb: parameter out of range");
    end

    arb_state_e            state_q, state_d;
    logic [GID_W-1:0]      grant_q, grant_d;
    logic [GID_W-1:0]      rr_q, rr_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic                  push_n_q, push_n_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [GID_W-1:0]      pick_idx;
    logic                  pick_any;
    logic                  stall;
    logic                  own_valid;
    logic                  own_last;
    logic [DATA_WIDTH-1:0] own_data;
    logic                  accept;
    logic [BEAT_W-1:0]     beat_inc;
    logic                  done;
    logic [GID_W-1:0]      rr_next;

`ifdef EW_FIFO_ARB_TIMEOUT_EN
    logic [TMO_W-1:0]      idle_q, idle_d;
    logic                  tmo_q, tmo_d;
`endif

    ew_rr_pick #(.N(NUM_REQ), .W(GID_W)) u_pick (
        .req     (bus.req_valid),
        .ptr     (rr_q),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    // push_af only matters while a push is in flight, since status lags the push by a cycle.
    always_comb begin
        stall     = bus.push_full | (bus.push_af & ~push_n_q);
        own_valid = bus.req_valid[grant_q];
        own_last  = bus.req_last[grant_q];
        own_data  = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
        accept    = (state_q == ST_GRANT) & own_valid & ~stall;
        beat_inc  = beat_q + 1'b1;
        done      = accept & (own_last | (beat_inc == BEAT_W'(BURST_MAX)));
        rr_next   = (grant_q == GID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            beat_q   <= '0;
            push_n_q <= 1'b1;
            data_q   <= '0;
`ifdef EW_FIFO_ARB_TIMEOUT_EN
            idle_q   <= '0;
            tmo_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            beat_q   <= beat_d;
            push_n_q <= push_n_d;
            data_q   <= data_d;
`ifdef EW_FIFO_ARB_TIMEOUT_EN
            idle_q   <= idle_d;
            tmo_q    <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        beat_d   = beat_q;
        push_n_d = 1'b1;
        data_d   = data_q;
`ifdef EW_FIFO_ARB_TIMEOUT_EN
        idle_d   = idle_q;
        tmo_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef EW_FIFO_ARB_TIMEOUT_EN
                idle_d = '0;
`endif
                if (pick_any) begin
                    state_d = ST_GRANT;
                    grant_d = pick_idx;
                    beat_d  = '0;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    push_n_d = 1'b0;
                    data_d   = own_data;
                    beat_d   = beat_inc;
                end
                if (done) begin
                    state_d = ST_IDLE;
                    rr_d    = rr_next;
                end
`ifdef EW_FIFO_ARB_TIMEOUT_EN
                if (own_valid) begin
                    idle_d = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                    if (idle_d == TMO_W'(TIMEOUT)) begin
                        state_d = ST_IDLE;
                        rr_d    = rr_next;
                        tmo_d   = 1'b1;
                    end
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = '0;
        if (state_q == ST_GRANT) bus.req_ready[grant_q] = ~stall;
    end

    assign busy           = (state_q == ST_GRANT);
    assign grant_id       = grant_q;
    assign bus.push_req_n = push_n_q;
    assign bus.fifo_data  = data_q;
`ifdef EW_FIFO_ARB_TIMEOUT_EN
    assign timeout_err    = tmo_q;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule
